// File: rtl/pin_share_ctrl.sv
// Time-shares bidirectional header pins between peripheral drivers, with a
// break-before-make guard on every owner change and a sticky config lock.
module pin_share_ctrl #(
   parameter int unsigned NumPins     = 8,
   parameter int unsigned NumSrc      = 4,
   parameter int unsigned GuardCycles = 4,
   parameter int unsigned ResetSel    = NumSrc,
   parameter logic        InDefault   = 1'b1,
   parameter int unsigned SelW        = $clog2(NumSrc + 1),
   parameter int unsigned PinW        = (NumPins > 1) ? $clog2(NumPins) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cfg_we_i,
   input  logic [PinW-1:0]             cfg_pin_i,
   input  logic [SelW-1:0]             cfg_sel_i,
   input  logic                        cfg_lock_i,
   output logic                        cfg_err_o,
   input  logic [NumSrc*NumPins-1:0]   src_out_i,
   input  logic [NumSrc*NumPins-1:0]   src_oe_i,
   output logic [NumSrc*NumPins-1:0]   src_in_o,
   output logic [NumPins-1:0]          pin_out_o,
   output logic [NumPins-1:0]          pin_oe_o,
   input  logic [NumPins-1:0]          pin_in_i,
   output logic [NumPins*SelW-1:0]     owner_o,
   output logic [NumPins-1:0]          busy_o,
   output logic                        locked_o
);

   localparam int unsigned CntW = $clog2(GuardCycles + 1);

   typedef enum logic {
      ST_ACTIVE,
      ST_GUARD
   } pin_state_e;

   pin_state_e      state_q [NumPins];
   pin_state_e      state_d [NumPins];
   logic [SelW-1:0] owner_q [NumPins];
   logic [SelW-1:0] owner_d [NumPins];
   logic [SelW-1:0] pend_q  [NumPins];
   logic [SelW-1:0] pend_d  [NumPins];
   logic [CntW-1:0] cnt_q   [NumPins];
   logic [CntW-1:0] cnt_d   [NumPins];

   logic               locked_q;
   logic               err_q;
   logic               wr_bad;
   logic               wr_ok;
   logic [SelW-1:0]    sel_c;
   logic [NumPins-1:0] wr_hit;

   // Out-of-range owner codes fold to "none" rather than raising an error.
   always_comb begin
      sel_c  = (cfg_sel_i > SelW'(NumSrc)) ? SelW'(NumSrc) : cfg_sel_i;
      wr_bad = cfg_we_i & (locked_q | (32'(cfg_pin_i) >= NumPins));
      wr_ok  = cfg_we_i & ~wr_bad;
      wr_hit = '0;
      for (int unsigned p = 0; p < NumPins; p++) begin
         wr_hit[p] = wr_ok & (cfg_pin_i == PinW'(p));
      end
   end

   // A write during GUARD always reloads the counter, so a write coinciding
   // with expiry restarts the guard instead of briefly re-entering ACTIVE.
   always_comb begin
      for (int unsigned p = 0; p < NumPins; p++) begin
         state_d[p] = state_q[p];
         owner_d[p] = owner_q[p];
         pend_d[p]  = pend_q[p];
         cnt_d[p]   = cnt_q[p];
         unique case (state_q[p])
            ST_ACTIVE: begin
               if (wr_hit[p] && (sel_c != owner_q[p])) begin
                  state_d[p] = ST_GUARD;
                  pend_d[p]  = sel_c;
                  cnt_d[p]   = CntW'(GuardCycles);
               end
            end
            ST_GUARD: begin
               if (wr_hit[p]) begin
                  pend_d[p] = sel_c;
                  cnt_d[p]  = CntW'(GuardCycles);
               end else if (cnt_q[p] == CntW'(1)) begin
                  owner_d[p] = pend_q[p];
                  state_d[p] = ST_ACTIVE;
                  cnt_d[p]   = '0;
               end else begin
                  cnt_d[p] = cnt_q[p] - CntW'(1);
               end
            end
            default: state_d[p] = ST_ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned p = 0; p < NumPins; p++) begin
            state_q[p] <= ST_ACTIVE;
            owner_q[p] <= SelW'(ResetSel);
            pend_q[p]  <= SelW'(ResetSel);
            cnt_q[p]   <= '0;
         end
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         for (int unsigned p = 0; p < NumPins; p++) begin
            state_q[p] <= state_d[p];
            owner_q[p] <= owner_d[p];
            pend_q[p]  <= pend_d[p];
            cnt_q[p]   <= cnt_d[p];
         end
         locked_q <= locked_q | cfg_lock_i;
         err_q    <= wr_bad;
      end
   end

   always_comb begin
      pin_out_o = '0;
      pin_oe_o  = '0;
      busy_o    = '0;
      owner_o   = '0;
      src_in_o  = {(NumSrc*NumPins){InDefault}};
      for (int unsigned p = 0; p < NumPins; p++) begin
         busy_o[p]               = (state_q[p] == ST_GUARD);
         owner_o[p*SelW +: SelW] = owner_q[p];
         for (int unsigned s = 0; s < NumSrc; s++) begin
            if ((state_q[p] == ST_ACTIVE) && (owner_q[p] == SelW'(s))) begin
               pin_out_o[p]           = src_out_i[s*NumPins + p];
               pin_oe_o[p]            = src_oe_i[s*NumPins + p];
               src_in_o[s*NumPins + p] = pin_in_i[p];
            end
         end
      end
   end

   assign cfg_err_o = err_q;
   assign locked_o  = locked_q;

endmodule

// File: tb/tb_pin_share_ctrl.sv
// Directed bench for pin_share_ctrl: expectations are queued with a due cycle
// and compared against the DUT when that cycle is reached.
module tb_pin_share_ctrl;

   localparam int K_OE    = 0;
   localparam int K_OUT   = 1;
   localparam int K_BUSY  = 2;
   localparam int K_OWN   = 3;
   localparam int K_LOCK  = 4;
   localparam int K_ERR   = 5;
   localparam int K_SRCIN = 6;
   localparam int K_ERRB  = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        cfg_we, cfg_lock, cfg_err, locked;
   logic [2:0]  cfg_pin, cfg_sel;
   logic [31:0] src_out, src_oe, src_in;
   logic [7:0]  pin_out, pin_oe, pin_in, busy;
   logic [23:0] owner;

   logic        we_b, lock_b, err_b, locked_b;
   logic [2:0]  pin_b, sel_b;
   logic [23:0] src_out_b, src_oe_b, src_in_b;
   logic [5:0]  pin_out_b, pin_oe_b, pin_in_b, busy_b;
   logic [17:0] owner_b;

   pin_share_ctrl dut (
      .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_pin_i(cfg_pin),
      .cfg_sel_i(cfg_sel), .cfg_lock_i(cfg_lock), .cfg_err_o(cfg_err),
      .src_out_i(src_out), .src_oe_i(src_oe), .src_in_o(src_in),
      .pin_out_o(pin_out), .pin_oe_o(pin_oe), .pin_in_i(pin_in),
      .owner_o(owner), .busy_o(busy), .locked_o(locked)
   );

   pin_share_ctrl #(.NumPins(6)) dut_b (
      .clk_i(clk), .rst_i(rst), .cfg_we_i(we_b), .cfg_pin_i(pin_b),
      .cfg_sel_i(sel_b), .cfg_lock_i(lock_b), .cfg_err_o(err_b),
      .src_out_i(src_out_b), .src_oe_i(src_oe_b), .src_in_o(src_in_b),
      .pin_out_o(pin_out_b), .pin_oe_o(pin_oe_b), .pin_in_i(pin_in_b),
      .owner_o(owner_b), .busy_o(busy_b), .locked_o(locked_b)
   );

   typedef struct {
      int unsigned due;
      int          kind;
      logic [63:0] val;
      string       tag;
   } exp_t;

   exp_t        sbq[$];
   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   logic [2:0]  mown [8];

   function automatic logic [63:0] observe(int k);
      case (k)
         K_OE:    return 64'(pin_oe);
         K_OUT:   return 64'(pin_out);
         K_BUSY:  return 64'(busy);
         K_OWN:   return 64'(owner);
         K_LOCK:  return 64'(locked);
         K_ERR:   return 64'(cfg_err);
         K_SRCIN: return 64'(src_in);
         default: return 64'(err_b);
      endcase
   endfunction

   function automatic logic [63:0] pack_own();
      logic [23:0] v;
      for (int i = 0; i < 8; i++) v[i*3 +: 3] = mown[i];
      return 64'(v);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_at(input int unsigned dly, input int k, input logic [63:0] v,
                            input string tag);
      sbq.push_back('{cyc + dly, k, v, tag});
   endtask

   task automatic drain();
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].due <= cyc) begin
            check(sbq[i].tag, observe(sbq[i].kind), sbq[i].val);
            sbq.delete(i);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drain();
   endtask

   task automatic wr_step(input logic [2:0] p, input logic [2:0] s);
      cfg_we  = 1'b1;
      cfg_pin = p;
      cfg_sel = s;
      step();
      cfg_we  = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      cfg_we   = 1'b0; cfg_pin = '0; cfg_sel = '0; cfg_lock = 1'b0;
      src_out  = {8'hF0, 8'h0F, 8'hFF, 8'h3C};
      src_oe   = '1;
      pin_in   = 8'h81;
      we_b     = 1'b0; pin_b = '0; sel_b = '0; lock_b = 1'b0;
      src_out_b = '0; src_oe_b = '0; pin_in_b = '0;
      for (int i = 0; i < 8; i++) mown[i] = 3'd4;
      repeat (2) step();
      rst = 1'b0;
      step();

      // reset state
      expect_at(0, K_OE, 64'h0, "rst_oe");
      expect_at(0, K_OUT, 64'h0, "rst_out");
      expect_at(0, K_BUSY, 64'h0, "rst_busy");
      expect_at(0, K_OWN, pack_own(), "rst_owner");
      expect_at(0, K_LOCK, 64'h0, "rst_lock");
      expect_at(0, K_ERR, 64'h0, "rst_err");
      expect_at(0, K_SRCIN, 64'hFFFF_FFFF, "rst_srcin");
      expect_at(0, K_ERRB, 64'h0, "rst_errb");
      drain();

      // pin2 -> src1, guard of four cycles
      for (int k = 1; k <= 4; k++) begin
         expect_at(k, K_BUSY, 64'h04, "t2_busy");
         expect_at(k, K_OE, 64'h00, "t2_oe");
         expect_at(k, K_OWN, pack_own(), "t2_own_old");
      end
      expect_at(1, K_ERR, 64'h0, "t2_err");
      mown[2] = 3'd1;
      expect_at(5, K_OE, 64'h04, "t2_oe_new");
      expect_at(5, K_OUT, 64'h04, "t2_out_new");
      expect_at(5, K_BUSY, 64'h00, "t2_busy_done");
      expect_at(5, K_OWN, pack_own(), "t2_own_new");
      expect_at(5, K_SRCIN, 64'hFFFF_FBFF, "t2_srcin");
      wr_step(3'd2, 3'd1);
      repeat (4) step();

      // same-owner write is a no-op
      expect_at(1, K_BUSY, 64'h00, "noop_busy");
      expect_at(1, K_OE, 64'h04, "noop_oe");
      wr_step(3'd2, 3'd1);

      // write at the last guard cycle restarts the guard
      for (int k = 1; k <= 8; k++) begin
         expect_at(k, K_BUSY, 64'h04, "t3_busy");
         expect_at(k, K_OE, 64'h00, "t3_oe_off");
         expect_at(k, K_OWN, pack_own(), "t3_own_held");
      end
      mown[2] = 3'd3;
      expect_at(9, K_OWN, pack_own(), "t3_own_new");
      expect_at(9, K_OE, 64'h04, "t3_oe_new");
      expect_at(9, K_OUT, 64'h00, "t3_out_new");
      expect_at(9, K_BUSY, 64'h00, "t3_busy_done");
      expect_at(9, K_SRCIN, 64'hFBFF_FFFF, "t3_srcin");
      wr_step(3'd2, 3'd0);
      repeat (3) step();
      wr_step(3'd2, 3'd3);
      repeat (4) step();

      // pin5 -> src0, input routing
      for (int k = 1; k <= 4; k++) begin
         expect_at(k, K_BUSY, 64'h20, "t4_busy");
         expect_at(k, K_OE, 64'h04, "t4_oe_guard");
      end
      expect_at(1, K_SRCIN, 64'hFBFF_FFFF, "t4_srcin_guard");
      mown[5] = 3'd0;
      expect_at(5, K_OE, 64'h24, "t4_oe_new");
      expect_at(5, K_OUT, 64'h20, "t4_out_new");
      expect_at(5, K_OWN, pack_own(), "t4_own_new");
      expect_at(5, K_SRCIN, 64'hFBFF_FFDF, "t4_srcin");
      wr_step(3'd5, 3'd0);
      repeat (4) step();

      // sel=7 clamps to none, not an error
      expect_at(1, K_ERR, 64'h0, "t4_clamp_err");
      for (int k = 1; k <= 4; k++) expect_at(k, K_BUSY, 64'h20, "t4c_busy");
      mown[5] = 3'd4;
      expect_at(5, K_OWN, pack_own(), "t4c_own");
      expect_at(5, K_OE, 64'h04, "t4c_oe");
      expect_at(5, K_SRCIN, 64'hFBFF_FFFF, "t4c_srcin");
      wr_step(3'd5, 3'd7);
      repeat (4) step();

      // out-of-range pin index on the six-pin instance
      expect_at(1, K_ERRB, 64'h1, "bad_pin6_err");
      expect_at(2, K_ERRB, 64'h0, "good_pin_err");
      expect_at(3, K_ERRB, 64'h1, "bad_pin7_err");
      expect_at(4, K_ERRB, 64'h0, "bad_pin_pulse");
      we_b = 1'b1; pin_b = 3'd6;
      step();
      pin_b = 3'd1;
      step();
      pin_b = 3'd7;
      step();
      we_b = 1'b0;
      step();

      // lock: same-cycle write applies, later writes are rejected
      expect_at(1, K_LOCK, 64'h1, "lock_set");
      expect_at(1, K_ERR, 64'h0, "lock_wr_ok");
      expect_at(2, K_ERR, 64'h1, "lock_err");
      expect_at(3, K_ERR, 64'h0, "lock_err_pulse");
      for (int k = 1; k <= 4; k++) expect_at(k, K_BUSY, 64'h01, "lock_busy");
      mown[0] = 3'd1;
      expect_at(5, K_OWN, pack_own(), "lock_own");
      expect_at(5, K_OE, 64'h05, "lock_oe");
      expect_at(5, K_OUT, 64'h01, "lock_out");
      cfg_lock = 1'b1;
      cfg_we = 1'b1; cfg_pin = 3'd0; cfg_sel = 3'd1;
      step();
      cfg_lock = 1'b0;
      cfg_sel = 3'd2;
      step();
      cfg_we = 1'b0;
      repeat (3) step();
      expect_at(1, K_ERR, 64'h1, "lock_err2");
      expect_at(1, K_BUSY, 64'h00, "lock_no_guard");
      wr_step(3'd5, 3'd0);

      // async reset clears lock and owners
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) mown[i] = 3'd4;
      check("arst_lock", observe(K_LOCK), 64'h0);
      check("arst_oe", observe(K_OE), 64'h0);
      check("arst_own", observe(K_OWN), pack_own());
      step();
      rst = 1'b0;
      step();

      // reset two cycles into a guard discards the pending owner
      expect_at(1, K_BUSY, 64'h08, "g6_busy1");
      expect_at(2, K_BUSY, 64'h08, "g6_busy2");
      wr_step(3'd3, 3'd2);
      step();
      #2 rst = 1'b1;
      #1;
      check("g6_arst_busy", observe(K_BUSY), 64'h0);
      check("g6_arst_oe", observe(K_OE), 64'h0);
      check("g6_arst_own", observe(K_OWN), pack_own());
      step();
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         expect_at(k, K_OWN, pack_own(), "g6_own_kept");
         expect_at(k, K_OE, 64'h0, "g6_oe");
         expect_at(k, K_BUSY, 64'h0, "g6_busy");
      end
      repeat (6) step();

      check("sb_leftover", 64'(sbq.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
